match_controller: RTL and testbench

//  Owns the combat rules of the two-player fighting game: qualifies raw sprite-overlap hit

---
 rtl/fighting_pkg.sv | 21 ++
 rtl/frame_down_counter.sv | 39 +++
 rtl/match_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_match_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fighting_pkg.sv
// Shared types and constants for the fighting-game combat logic.
package fighting_pkg;

    localparam int unsigned HW = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_KO        = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter that decrements once per frame tick and stops at zero.
module frame_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         nonzero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over a decrement landing in the same cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/match_controller.sv
// Combat rules and match sequencing: hit qualification, damage, invincibility,
// round tracking and the IDLE/READY/FIGHT/KO/GAME_OVER flow.
module match_controller
    import fighting_pkg::*;
#(
    parameter int unsigned HW            = fighting_pkg::HW,
    parameter int unsigned HEALTH_MAX    = 300,
    parameter int unsigned DAMAGE        = 100,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned READY_FRAMES  = 90,
    parameter int unsigned KO_FRAMES     = 120,
    parameter int unsigned ROUNDS_TO_WIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          start,
    input  logic          p1_hit,
    input  logic          p2_hit,
    output logic [HW-1:0] p1_health,
    output logic [HW-1:0] p2_health,
    output logic          p1_inv,
    output logic          p2_inv,
    output logic          move_en,
    output logic [2:0]    state,
    output logic [1:0]    p1_rounds,
    output logic [1:0]    p2_rounds,
    output logic [1:0]    winner
);

    localparam int unsigned PHASE_MAX = (READY_FRAMES > KO_FRAMES) ? READY_FRAMES : KO_FRAMES;
    localparam int unsigned IW = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned PW = $clog2(PHASE_MAX + 1);

    localparam logic [HW-1:0] H_MAX      = HW'(HEALTH_MAX);
    localparam logic [HW-1:0] DMG        = HW'(DAMAGE);
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);
    localparam logic [PW-1:0] READY_LOAD = PW'(READY_FRAMES);
    localparam logic [PW-1:0] KO_LOAD    = PW'(KO_FRAMES);
    localparam logic [1:0]    R_WIN      = 2'(ROUNDS_TO_WIN);

    state_t        state_q, state_d;
    winner_t       winner_q, winner_d;
    logic [HW-1:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [1:0]    p1_rounds_q, p1_rounds_d, p2_rounds_q, p2_rounds_d;
    logic          move_en_q;
    logic          start_q;

    logic          start_re;
    logic          p1_acc, p2_acc;
    logic [HW-1:0] p1_sub, p2_sub;

    logic          inv1_load, inv2_load, phase_load;
    logic [IW-1:0] inv1_val, inv2_val, inv1_cnt, inv2_cnt;
    logic [PW-1:0] phase_val, phase_cnt;
    logic          inv1_nz, inv2_nz, phase_nz;
    logic          phase_expire;

    frame_down_counter #(.W(IW)) u_p1_inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (inv1_load),
        .load_val (inv1_val),
        .tick     (frame_tick),
        .count    (inv1_cnt),
        .nonzero  (inv1_nz)
    );

    frame_down_counter #(.W(IW)) u_p2_inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (inv2_load),
        .load_val (inv2_val),
        .tick     (frame_tick),
        .count    (inv2_cnt),
        .nonzero  (inv2_nz)
    );

    frame_down_counter #(.W(PW)) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val (phase_val),
        .tick     (frame_tick),
        .count    (phase_cnt),
        .nonzero  (phase_nz)
    );

    assign start_re     = start & ~start_q;
    assign phase_expire = frame_tick & phase_nz & (phase_cnt == PW'(1));
    assign p1_acc       = (state_q == ST_FIGHT) & p1_hit & ~inv1_nz;
    assign p2_acc       = (state_q == ST_FIGHT) & p2_hit & ~inv2_nz;
    assign p1_sub       = (p1_health_q <= DMG) ? '0 : (p1_health_q - DMG);
    assign p2_sub       = (p2_health_q <= DMG) ? '0 : (p2_health_q - DMG);

    // Match FSM next state, damage, round awards and timer loads.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_rounds_d = p1_rounds_q;
        p2_rounds_d = p2_rounds_q;
        inv1_load   = 1'b0;
        inv1_val    = '0;
        inv2_load   = 1'b0;
        inv2_val    = '0;
        phase_load  = 1'b0;
        phase_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_re) begin
                    state_d    = ST_READY;
                    phase_load = 1'b1;
                    phase_val  = READY_LOAD;
                end
            end
            ST_READY: begin
                if (phase_expire) begin
                    state_d = ST_FIGHT;
                end
            end
            ST_FIGHT: begin
                if (p1_acc) begin
                    p1_health_d = p1_sub;
                    inv1_load   = 1'b1;
                    inv1_val    = INV_LOAD;
                end
                if (p2_acc) begin
                    p2_health_d = p2_sub;
                    inv2_load   = 1'b1;
                    inv2_val    = INV_LOAD;
                end
                if ((p1_health_d == '0) || (p2_health_d == '0)) begin
                    state_d    = ST_KO;
                    phase_load = 1'b1;
                    phase_val  = KO_LOAD;
                    if ((p1_health_d == '0) && (p2_health_d == '0)) begin
                        winner_d = WIN_DRAW;
                    end else if (p2_health_d == '0) begin
                        winner_d = WIN_P1;
                        if (p1_rounds_q < R_WIN) p1_rounds_d = p1_rounds_q + 2'd1;
                    end else begin
                        winner_d = WIN_P2;
                        if (p2_rounds_q < R_WIN) p2_rounds_d = p2_rounds_q + 2'd1;
                    end
                end
            end
            ST_KO: begin
                if (phase_expire) begin
                    if (p1_rounds_q == R_WIN) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_P1;
                    end else if (p2_rounds_q == R_WIN) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d    = ST_READY;
                        winner_d   = WIN_NONE;
                        phase_load = 1'b1;
                        phase_val  = READY_LOAD;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_re) begin
                    state_d     = ST_READY;
                    winner_d    = WIN_NONE;
                    p1_rounds_d = '0;
                    p2_rounds_d = '0;
                    phase_load  = 1'b1;
                    phase_val   = READY_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keyed on the next state so health and invincibility are already
        // restored on the first READY cycle, not one cycle later.
        if (state_d == ST_READY) begin
            p1_health_d = H_MAX;
            p2_health_d = H_MAX;
            inv1_load   = 1'b1;
            inv1_val    = '0;
            inv2_load   = 1'b1;
            inv2_val    = '0;
        end
    end

    // State, health, rounds and winner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            winner_q    <= WIN_NONE;
            p1_health_q <= H_MAX;
            p2_health_q <= H_MAX;
            p1_rounds_q <= '0;
            p2_rounds_q <= '0;
            move_en_q   <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_rounds_q <= p1_rounds_d;
            p2_rounds_q <= p2_rounds_d;
            move_en_q   <= (state_d == ST_FIGHT);
            start_q     <= start;
        end
    end

    assign p1_health = p1_health_q;
    assign p2_health = p2_health_q;
    assign p1_inv    = inv1_nz;
    assign p2_inv    = inv2_nz;
    assign move_en   = move_en_q;
    assign state     = state_q;
    assign p1_rounds = p1_rounds_q;
    assign p2_rounds = p2_rounds_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed scoreboard bench for match_controller.
module tb_match_controller;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, start, p1_hit, p2_hit;
    logic [10:0] p1_health, p2_health;
    logic        p1_inv, p2_inv, move_en;
    logic [2:0]  state;
    logic [1:0]  p1_rounds, p2_rounds, winner;

    always #5 clk = ~clk;

    match_controller #(
        .HW            (11),
        .HEALTH_MAX    (300),
        .DAMAGE        (100),
        .INVULN_FRAMES (60),
        .READY_FRAMES  (90),
        .KO_FRAMES     (120),
        .ROUNDS_TO_WIN (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_hit     (p1_hit),
        .p2_hit     (p2_hit),
        .p1_health  (p1_health),
        .p2_health  (p2_health),
        .p1_inv     (p1_inv),
        .p2_inv     (p2_inv),
        .move_en    (move_en),
        .state      (state),
        .p1_rounds  (p1_rounds),
        .p2_rounds  (p2_rounds),
        .winner     (winner)
    );

    typedef struct {
        string tag;
        int st; int h1; int h2; int i1; int i2; int mv; int r1; int r2; int w;
    } snap_t;

    snap_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int st, input int h1, input int h2,
                        input int i1, input int i2, input int mv,
                        input int r1, input int r2, input int w);
        snap_t s;
        s.tag = tag; s.st = st; s.h1 = h1; s.h2 = h2; s.i1 = i1; s.i2 = i2;
        s.mv = mv; s.r1 = r1; s.r2 = r2; s.w = w;
        sb.push_back(s);
    endtask

    task automatic check_dut();
        snap_t s;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
        end else begin
            s = sb.pop_front();
            chk({s.tag, ".state"},     32'(state),     32'(s.st));
            chk({s.tag, ".p1_health"}, 32'(p1_health), 32'(s.h1));
            chk({s.tag, ".p2_health"}, 32'(p2_health), 32'(s.h2));
            chk({s.tag, ".p1_inv"},    32'(p1_inv),    32'(s.i1));
            chk({s.tag, ".p2_inv"},    32'(p2_inv),    32'(s.i2));
            chk({s.tag, ".move_en"},   32'(move_en),   32'(s.mv));
            chk({s.tag, ".p1_rounds"}, 32'(p1_rounds), 32'(s.r1));
            chk({s.tag, ".p2_rounds"}, 32'(p2_rounds), 32'(s.r2));
            chk({s.tag, ".winner"},    32'(winner),    32'(s.w));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;

        // Reset and entry into the first round
        push("reset", 0, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); step();
        check_dut();
        rst_n = 1'b1;
        push("idle_hold", 0, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();
        p1_hit = 1'b1;
        push("idle_hit_ignored", 0, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();
        p1_hit = 1'b0;
        start = 1'b1;
        push("ready_entry", 1, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();
        p1_hit = 1'b1;
        push("ready_hit_ignored", 1, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();
        p1_hit = 1'b0;
        push("ready_89", 1, 300, 300, 0, 0, 0, 0, 0, 0);
        frames(89); check_dut();
        push("fight_entry", 2, 300, 300, 0, 0, 1, 0, 0, 0);
        frames(1); check_dut();

        // Single hit and invincibility window
        p2_hit = 1'b1;
        push("p2_hit1", 2, 300, 200, 0, 1, 1, 0, 0, 0);
        step(); check_dut();
        p2_hit = 1'b0;
        start = 1'b0; step(); start = 1'b1;
        push("fight_start_ignored", 2, 300, 200, 0, 1, 1, 0, 0, 0);
        step(); check_dut();
        push("inv_59", 2, 300, 200, 0, 1, 1, 0, 0, 0);
        frames(59); check_dut();
        push("inv_60", 2, 300, 200, 0, 0, 1, 0, 0, 0);
        frames(1); check_dut();

        // Held hit level: re-hit only after invincibility ends, then KO
        p2_hit = 1'b1;
        push("held_hit2", 2, 300, 100, 0, 1, 1, 0, 0, 0);
        step(); check_dut();
        push("held_rejected", 2, 300, 100, 0, 1, 1, 0, 0, 0);
        frames(59); check_dut();
        frame_tick = 1'b1;
        push("held_inv_end", 2, 300, 100, 0, 0, 1, 0, 0, 0);
        step(); check_dut();
        frame_tick = 1'b0;
        push("ko_p1_wins", 3, 300, 0, 0, 1, 0, 1, 0, 1);
        step(); check_dut();
        p2_hit = 1'b0;
        push("ko_119", 3, 300, 0, 0, 0, 0, 1, 0, 1);
        frames(119); check_dut();
        push("round2_ready", 1, 300, 300, 0, 0, 0, 1, 0, 0);
        frames(1); check_dut();
        push("round2_fight", 2, 300, 300, 0, 0, 1, 1, 0, 0);
        frames(90); check_dut();

        // Trades down to a double KO
        p1_hit = 1'b1; p2_hit = 1'b1;
        push("trade1", 2, 200, 200, 1, 1, 1, 1, 0, 0);
        step(); check_dut();
        p1_hit = 1'b0; p2_hit = 1'b0;
        push("trade1_inv_end", 2, 200, 200, 0, 0, 1, 1, 0, 0);
        frames(60); check_dut();
        p1_hit = 1'b1; p2_hit = 1'b1;
        push("trade2", 2, 100, 100, 1, 1, 1, 1, 0, 0);
        step(); check_dut();
        p1_hit = 1'b0; p2_hit = 1'b0;
        frames(60);
        p1_hit = 1'b1; p2_hit = 1'b1;
        push("double_ko", 3, 0, 0, 1, 1, 0, 1, 0, 3);
        step(); check_dut();
        p1_hit = 1'b0; p2_hit = 1'b0;
        push("replay_ready", 1, 300, 300, 0, 0, 0, 1, 0, 0);
        frames(120); check_dut();
        push("round3_fight", 2, 300, 300, 0, 0, 1, 1, 0, 0);
        frames(90); check_dut();

        // Second round win ends the match, restart from GAME_OVER
        p2_hit = 1'b1;
        step();
        frames(120);
        p2_hit = 1'b0;
        push("ko_match_point", 3, 300, 0, 0, 1, 0, 2, 0, 1);
        check_dut();
        push("game_over", 4, 300, 0, 0, 0, 0, 2, 0, 1);
        frames(120); check_dut();
        start = 1'b0;
        push("game_over_frozen", 4, 300, 0, 0, 0, 0, 2, 0, 1);
        step(); check_dut();
        start = 1'b1;
        push("restart_ready", 1, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();

        // Reset in the middle of a fight while invincible
        push("restart_fight", 2, 300, 300, 0, 0, 1, 0, 0, 0);
        frames(90); check_dut();
        p1_hit = 1'b1;
        push("p1_hit_before_reset", 2, 200, 300, 1, 0, 1, 0, 0, 0);
        step(); check_dut();
        p1_hit = 1'b0;
        rst_n = 1'b0; start = 1'b0;
        push("mid_reset", 0, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();
        rst_n = 1'b1;
        push("post_reset_idle", 0, 300, 300, 0, 0, 0, 0, 0, 0);
        step(); check_dut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
